dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Sequencing controller for the direct-mapped data cache: 16 lines, one 32-bit word per line.
- Address split: tag = addr[31:6], index = addr[5:2]; addr[1:0] ignored (word access only).
- Sits between the CPU memory stage and the main-memory port.
- Serves read hits in the same cycle, refills on read miss, writes through to memory, and performs single-line or whole-cache invalidation (flush).

Parameters:
- LINES, 16, number of cache lines; must equal 2**INDEX_W.
- INDEX_W, 4, index width, taken from addr[5:2].
- TAG_W, 26, tag width, taken from addr[31:6].

Ports:
- iClk  in  1  clock, rising edge.
- iRstN  in  1  asynchronous active-low reset.
- iAddress  in  32  CPU access address.
- iReadEn  in  1  CPU read request, held until oStall is low.
- iWriteEn  in  1  CPU write request, held until oStall is low.
- iWriteData  in  32  CPU write data.
- oReadData  out  32  read data, valid when oHit=1.
- oHit  out  1  read hit this cycle.
- oStall  out  1  CPU must hold its request.
- iFlushEn  in  1  invalidate the line at iFlushAddress (one-cycle pulse).
- iFlushAll  in  1  invalidate all lines (one-cycle pulse).
- iFlushAddress  in  32  flush address; index = [5:2].
- oFlushBusy  out  1  flush-all sweep in progress.
- oMemReq  out  1  memory request.
- oMemWe  out  1  1 = memory write, 0 = memory read.
- oMemAddr  out  32  memory word address, {addr[31:2],2'b00}.
- oMemWData  out  32  memory write data.
- iMemAck  in  1  memory accepted request / read data valid.
- iMemRData  in  32  memory read data, valid with iMemAck.

Behaviour:
- Reset: clock is iClk; reset is asynchronous, active-low on iRstN.
  - State IDLE, all valid bits 0, sweep counter 0.
  - oMemReq, oMemWe, oHit, oStall, oFlushBusy all 0; oMemAddr, oMemWData, oReadData 0.
  - Asserting reset mid-transaction drops oMemReq immediately; the pending refill is discarded.
- States: IDLE, RD_REQ, WR_REQ, FLUSH_ALL.
- IDLE, read hit (valid[idx] && tag match):
  - oHit=1, oReadData=line data, oStall=0, combinational in the same cycle.
- IDLE, read miss:
  - oStall=1; latch address; next state RD_REQ.
- RD_REQ:
  - oMemReq=1, oMemWe=0, oMemAddr=latched address, held stable until iMemAck.
  - On the iMemAck edge: write data, tag and valid=1 into the line; next state IDLE.
  - Next cycle hits with oStall=0, so minimum miss penalty is 2 cycles (ack in the first RD_REQ cycle).
- IDLE, write (write-through, no-write-allocate):
  - oStall=1; latch address and data; next state WR_REQ.
- WR_REQ:
  - oMemReq=1, oMemWe=1.
  - On iMemAck: if the line hits, update its data; a miss leaves the cache unchanged. Next state IDLE, oStall=0 in the next cycle.
- iReadEn && iWriteEn together: write takes priority; read is serviced afterwards.
- iFlushEn in IDLE: clear valid[iFlushAddress[5:2]] at the edge.
  - Same-cycle CPU access is stalled one cycle (oStall=1) and evaluated against the post-flush state.
- iFlushEn outside IDLE: registered as pending; applied on return to IDLE, before any new access.
- iFlushAll in IDLE: enter FLUSH_ALL.
  - Clear one line per cycle, index 0..15; oFlushBusy=1 and oStall=1 for 16 cycles.
  - Return to IDLE after index 15; the counter wraps to 0.
- iFlushAll outside IDLE: pending; taken on return to IDLE, with priority over a pending single flush.
- oMemReq never deasserts before iMemAck. iMemAck while oMemReq=0 is ignored.

Decomposition:
- Package dcache_pkg: TAG_W, INDEX_W, LINES, and the state enum type (IDLE, RD_REQ, WR_REQ, FLUSH_ALL).
- Sub-module dcache_line_store: valid/tag/data arrays.
  - Async read port at the index.
  - One write port: fill or update.
  - Per-index invalidate port.
  - Reset clears valid only.

Test Plan:
- Reset, then read 0x0000_0040 with ack after 3 cycles, data 0xDEADBEEF -> oStall=1 for 4 cycles, then oHit=1 and oReadData=0xDEADBEEF.
- Read 0x0000_0080 (same index 0, different tag) after the above -> miss, refill replaces the line; re-read of 0x40 misses.
- Write 0x0000_0040 = 0x12345678 on a hit line -> oMemReq/oMemWe=1 with oMemAddr=0x40 until ack; a subsequent read hits 0x12345678. Write to an uncached address -> memory written, cache unchanged.
- iFlushEn with iFlushAddress=0x44 (index 1) while line 1 is valid -> next read of that address misses; simultaneous read is stalled one cycle.
- iFlushAll pulse with 16 valid lines -> oFlushBusy high exactly 16 cycles, all subsequent reads miss; iFlushAll during RD_REQ is deferred until the refill ack.
- Assert iRstN=0 mid RD_REQ -> oMemReq drops the same cycle, all lines invalid after reset release.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry and controller state encoding for the direct-mapped data cache.
package dcache_pkg;

  localparam int TAG_W   = 26;
  localparam int INDEX_W = 4;
  localparam int LINES   = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_REQ    = 2'd1,
    WR_REQ    = 2'd2,
    FLUSH_ALL = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache: one async read port,
// one fill/update write port and one per-index invalidate port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES   = dcache_pkg::LINES,
  parameter int INDEX_W = dcache_pkg::INDEX_W,
  parameter int TAG_W   = dcache_pkg::TAG_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [31:0]        o_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [31:0]        i_wr_data,
  input  logic               i_inv_en,
  input  logic [INDEX_W-1:0] i_inv_idx
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Valid bits: the only state cleared by reset; a fill marks the line valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) r_valid[i_inv_idx] <= 1'b0;
      if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  // Tag/data storage: contents are meaningless while the valid bit is clear.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped data cache sequencer: same-cycle read hits, refill on read miss,
// write-through without allocate, single-line and whole-cache invalidation.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES   = dcache_pkg::LINES,
  parameter int INDEX_W = dcache_pkg::INDEX_W,
  parameter int TAG_W   = dcache_pkg::TAG_W
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [31:0] iAddress,
  input  logic        iReadEn,
  input  logic        iWriteEn,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oStall,
  input  logic        iFlushEn,
  input  logic        iFlushAll,
  input  logic [31:0] iFlushAddress,
  output logic        oFlushBusy,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LINES - 1);

  state_t             r_state, w_next;
  logic [29:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_pend_all, r_pend_one, r_wr_done;
  logic [INDEX_W-1:0] r_pend_idx, r_sweep;

  logic [INDEX_W-1:0] w_cpu_idx, w_flush_idx, w_lat_idx, w_rd_idx, w_inv_idx;
  logic [TAG_W-1:0]   w_cpu_tag, w_lat_tag, w_cmp_tag, w_line_tag;
  logic [31:0]        w_line_data, w_wr_data;
  logic               w_line_valid, w_line_hit, w_cpu_wr, w_cpu_req;
  logic               w_latch, w_wr_en, w_inv_en;
  logic               w_all_taken, w_one_taken, w_one_clr, w_done_clr;
  logic               w_unused;

  // Byte-offset and non-index flush-address bits carry no meaning for word lines.
  assign w_unused = ^{iAddress[1:0], iFlushAddress[31:2+INDEX_W], iFlushAddress[1:0]};

  assign w_cpu_idx   = iAddress[2 +: INDEX_W];
  assign w_cpu_tag   = iAddress[31 -: TAG_W];
  assign w_flush_idx = iFlushAddress[2 +: INDEX_W];
  assign w_lat_idx   = r_addr[INDEX_W-1:0];
  assign w_lat_tag   = r_addr[29 -: TAG_W];

  // IDLE looks up the live CPU address; memory states look up the latched one.
  assign w_rd_idx   = (r_state == IDLE) ? w_cpu_idx : w_lat_idx;
  assign w_cmp_tag  = (r_state == IDLE) ? w_cpu_tag : w_lat_tag;
  assign w_line_hit = w_line_valid && (w_line_tag == w_cmp_tag);

  // A completed write stays masked until the CPU sees oStall low, so a held
  // write is not repeated and a paired read gets serviced afterwards.
  assign w_cpu_wr  = iWriteEn && !r_wr_done;
  assign w_cpu_req = iReadEn || w_cpu_wr;
  assign w_wr_data = (r_state == RD_REQ) ? iMemRData : r_wdata;

  dcache_line_store #(
    .LINES  (LINES),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_store (
    .i_clk    (iClk),
    .i_rst_n  (iRstN),
    .i_rd_idx (w_rd_idx),
    .o_valid  (w_line_valid),
    .o_tag    (w_line_tag),
    .o_data   (w_line_data),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_lat_idx),
    .i_wr_tag (w_lat_tag),
    .i_wr_data(w_wr_data),
    .i_inv_en (w_inv_en),
    .i_inv_idx(w_inv_idx)
  );

  // Next-state and control decode; flushes outrank CPU accesses in IDLE.
  always_comb begin
    w_next      = r_state;
    oHit        = 1'b0;
    oStall      = 1'b0;
    oMemReq     = 1'b0;
    oMemWe      = 1'b0;
    w_latch     = 1'b0;
    w_wr_en     = 1'b0;
    w_inv_en    = 1'b0;
    w_inv_idx   = r_sweep;
    w_all_taken = 1'b0;
    w_one_taken = 1'b0;
    w_one_clr   = 1'b0;
    w_done_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_all || iFlushAll) begin
          w_next      = FLUSH_ALL;
          oStall      = w_cpu_req;
          w_all_taken = 1'b1;
          w_one_taken = 1'b1;
          w_one_clr   = 1'b1;
        end else if (r_pend_one) begin
          w_inv_en  = 1'b1;
          w_inv_idx = r_pend_idx;
          oStall    = w_cpu_req;
          w_one_clr = 1'b1;
        end else if (iFlushEn) begin
          w_inv_en    = 1'b1;
          w_inv_idx   = w_flush_idx;
          oStall      = w_cpu_req;
          w_one_taken = 1'b1;
        end else if (w_cpu_wr) begin
          oStall  = 1'b1;
          w_latch = 1'b1;
          w_next  = WR_REQ;
        end else if (iReadEn) begin
          if (w_line_hit) begin
            oHit = 1'b1;
          end else begin
            oStall  = 1'b1;
            w_latch = 1'b1;
            w_next  = RD_REQ;
          end
        end
        w_done_clr = !oStall;
      end
      RD_REQ: begin
        oMemReq = 1'b1;
        oStall  = 1'b1;
        if (iMemAck) begin
          w_wr_en = 1'b1;
          w_next  = IDLE;
        end
      end
      WR_REQ: begin
        oMemReq = 1'b1;
        oMemWe  = 1'b1;
        oStall  = 1'b1;
        if (iMemAck) begin
          w_wr_en = w_line_hit;
          w_next  = IDLE;
        end
      end
      FLUSH_ALL: begin
        oStall   = 1'b1;
        w_inv_en = 1'b1;
        if (r_sweep == LAST_IDX) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign oReadData  = oHit ? w_line_data : '0;
  assign oMemAddr   = oMemReq ? {r_addr, 2'b00} : '0;
  assign oMemWData  = oMemWe ? r_wdata : '0;
  assign oFlushBusy = (r_state == FLUSH_ALL);

  // State register; reset abandons any outstanding memory request at once.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Capture the missing/written address and write data when leaving IDLE.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_addr  <= iAddress[31:2];
      r_wdata <= iWriteData;
    end
  end

  // Deferred flush requests, sweep counter and write-completion mask.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_pend_all <= 1'b0;
      r_pend_one <= 1'b0;
      r_pend_idx <= '0;
      r_sweep    <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      if (iFlushAll && !w_all_taken) r_pend_all <= 1'b1;
      else if (w_all_taken)          r_pend_all <= 1'b0;
      if (iFlushEn && !w_one_taken) begin
        r_pend_one <= 1'b1;
        r_pend_idx <= w_flush_idx;
      end else if (w_one_clr) begin
        r_pend_one <= 1'b0;
      end
      if (r_state == FLUSH_ALL) r_sweep <= r_sweep + 1'b1;
      if (r_state == WR_REQ && iMemAck) r_wr_done <= 1'b1;
      else if (w_done_clr)              r_wr_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: the bench acts as CPU and main memory.
module tb_dcache_controller;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic [31:0] iAddress = '0;
  logic        iReadEn = 1'b0;
  logic        iWriteEn = 1'b0;
  logic [31:0] iWriteData = '0;
  logic [31:0] oReadData;
  logic        oHit;
  logic        oStall;
  logic        iFlushEn = 1'b0;
  logic        iFlushAll = 1'b0;
  logic [31:0] iFlushAddress = '0;
  logic        oFlushBusy;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemRData = '0;

  int          n_vec = 0;
  int          n_err = 0;
  int          nst;
  int          sum;
  int          busy;
  int          stall_busy;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;

  dcache_controller dut (
    .iClk(iClk), .iRstN(iRstN), .iAddress(iAddress), .iReadEn(iReadEn),
    .iWriteEn(iWriteEn), .iWriteData(iWriteData), .oReadData(oReadData),
    .oHit(oHit), .oStall(oStall), .iFlushEn(iFlushEn), .iFlushAll(iFlushAll),
    .iFlushAddress(iFlushAddress), .oFlushBusy(oFlushBusy), .oMemReq(oMemReq),
    .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .iMemAck(iMemAck), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a CPU access at the current falling edge and play memory: ack
  // arrives in the lat-th cycle of each request. Returns in the first cycle
  // with oStall low (inputs still held), counting the stalled cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int lat, output int nstall);
    int  rq;
    bit  done;
    iReadEn = rd; iWriteEn = wr; iAddress = a; iWriteData = wd;
    nstall = 0; rq = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!oStall) begin done = 1; break; end
      nstall++;
      if (oMemReq) begin
        rq++;
        if (rq == 1) begin cap_addr = oMemAddr; cap_we = oMemWe; cap_wdata = oMemWData; end
        if (rq == lat) begin iMemAck = 1'b1; iMemRData = rdat; end
      end else begin
        rq = 0;
      end
      @(negedge iClk);
      iMemAck = 1'b0;
    end
    if (!done) nstall = 9999;
  endtask

  task automatic release_cpu();
    @(negedge iClk);
    iReadEn = 1'b0; iWriteEn = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge iClk); #1;
    chk("rst_memreq", 32'(oMemReq), 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    chk("rst_hit", 32'(oHit), 32'd0);
    chk("rst_busy", 32'(oFlushBusy), 32'd0);
    chk("rst_outs", oMemAddr | oMemWData | oReadData | 32'(oMemWe), 32'd0);
    @(negedge iClk); iRstN = 1'b1;
    @(negedge iClk);

    // Read miss 0x40, ack in third request cycle
    access(1, 0, 32'h40, 0, 32'hDEADBEEF, 3, nst);
    chk("miss_stall", nst, 4);
    chk("miss_addr", cap_addr, 32'h40);
    chk("miss_we", 32'(cap_we), 32'd0);
    chk("miss_hit", 32'(oHit), 32'd1);
    chk("miss_data", oReadData, 32'hDEADBEEF);
    release_cpu();

    // Conflicting tag on index 0 replaces the line
    access(1, 0, 32'h80, 0, 32'hCAFEF00D, 1, nst);
    chk("conf_stall", nst, 2);
    chk("conf_data", oReadData, 32'hCAFEF00D);
    release_cpu();
    access(1, 0, 32'h40, 0, 32'hDEADBEEF, 1, nst);
    chk("reread_stall", nst, 2);
    release_cpu();

    // Write-through on a hit line, then on an uncached address
    access(0, 1, 32'h40, 32'h12345678, 0, 2, nst);
    chk("wr_stall", nst, 3);
    chk("wr_addr", cap_addr, 32'h40);
    chk("wr_we", 32'(cap_we), 32'd1);
    chk("wr_wdata", cap_wdata, 32'h12345678);
    release_cpu();
    access(1, 0, 32'h40, 0, 0, 1, nst);
    chk("wrhit_stall", nst, 0);
    chk("wrhit_data", oReadData, 32'h12345678);
    release_cpu();
    access(0, 1, 32'h100, 32'hAAAA5555, 0, 1, nst);
    chk("wrmiss_stall", nst, 2);
    chk("wrmiss_addr", cap_addr, 32'h100);
    release_cpu();
    access(1, 0, 32'h40, 0, 0, 1, nst);
    chk("noalloc_stall", nst, 0);
    chk("noalloc_data", oReadData, 32'h12345678);
    release_cpu();

    // Single-line flush with simultaneous read
    access(1, 0, 32'h44, 0, 32'h11111111, 1, nst);
    chk("l1_fill", nst, 2);
    release_cpu();
    iFlushEn = 1'b1; iFlushAddress = 32'h44; iReadEn = 1'b1; iAddress = 32'h44;
    #1;
    chk("flush_stall", 32'(oStall), 32'd1);
    chk("flush_hit", 32'(oHit), 32'd0);
    @(negedge iClk); iFlushEn = 1'b0;
    access(1, 0, 32'h44, 0, 32'h22222222, 1, nst);
    chk("postflush_stall", nst, 2);
    chk("postflush_data", oReadData, 32'h22222222);
    release_cpu();

    // Fill all 16 lines, then sweep
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      access(1, 0, 32'(i * 4), 0, 32'hA0 + 32'(i), 1, nst);
      sum += nst;
      release_cpu();
    end
    chk("fill16_stall", sum, 32);
    access(1, 0, 32'h0C, 0, 0, 1, nst);
    chk("fill16_hit", nst, 0);
    chk("fill16_data", oReadData, 32'hA3);
    release_cpu();
    iFlushAll = 1'b1;
    #1;
    chk("fa_first", 32'(oFlushBusy), 32'd0);
    @(negedge iClk); iFlushAll = 1'b0;
    busy = 0; stall_busy = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!oFlushBusy) break;
      busy++;
      if (oStall) stall_busy++;
      @(negedge iClk);
    end
    chk("fa_busy", busy, 16);
    chk("fa_stall", stall_busy, 16);
    access(1, 0, 32'h0C, 0, 32'h3C3C, 1, nst);
    chk("fa_miss0C", nst, 2);
    release_cpu();
    access(1, 0, 32'h3C, 0, 32'h3D3D, 1, nst);
    chk("fa_miss3C", nst, 2);
    release_cpu();

    // Flush-all during a refill waits for the ack
    iReadEn = 1'b1; iAddress = 32'h20;
    #1; chk("dfr_stall", 32'(oStall), 32'd1);
    @(negedge iClk); #1;
    chk("dfr_req", 32'(oMemReq), 32'd1);
    iFlushAll = 1'b1;
    @(negedge iClk); iFlushAll = 1'b0; #1;
    chk("dfr_busy_held", 32'(oFlushBusy), 32'd0);
    chk("dfr_req_held", 32'(oMemReq), 32'd1);
    iMemAck = 1'b1; iMemRData = 32'h55;
    @(negedge iClk); iMemAck = 1'b0; #1;
    chk("dfr_idle_stall", 32'(oStall), 32'd1);
    chk("dfr_idle_hit", 32'(oHit), 32'd0);
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge iClk); #1;
      if (!oFlushBusy) break;
      busy++;
    end
    chk("dfr_busy", busy, 16);
    #(-1ns + 1ns);
    access(1, 0, 32'h20, 0, 32'h66, 1, nst);
    chk("dfr_remiss", nst, 2);
    chk("dfr_data", oReadData, 32'h66);
    release_cpu();

    // Reset during a refill
    iReadEn = 1'b1; iAddress = 32'h08;
    @(negedge iClk); #1;
    chk("rstmid_req", 32'(oMemReq), 32'd1);
    chk("rstmid_addr", oMemAddr, 32'h08);
    #2 iRstN = 1'b0;
    #1;
    chk("rstmid_drop", 32'(oMemReq), 32'd0);
    iReadEn = 1'b0;
    @(negedge iClk); iRstN = 1'b1;
    @(negedge iClk);
    access(1, 0, 32'h20, 0, 32'h99, 1, nst);
    chk("rstmid_miss", nst, 2);
    chk("rstmid_data", oReadData, 32'h99);
    release_cpu();

    // Read and write together: write first, then the read hits the new data
    access(1, 1, 32'h20, 32'h77, 0, 2, nst);
    chk("rw_stall", nst, 3);
    chk("rw_we", 32'(cap_we), 32'd1);
    chk("rw_hit", 32'(oHit), 32'd1);
    chk("rw_data", oReadData, 32'h77);
    release_cpu();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
